// File: rtl/pkg_fft_output_dbg_pkg.sv
// Shared types for the HLS deadlock-monitor debug path.
//   dbg_state_e : reporter FSM states
//   rpt_rec_t   : report record layout at its widest supported widths
//   id_width()  : width of a monitor index for n monitors (never below 1)
package pkg_fft_output_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } dbg_state_e;

  localparam int unsigned MAX_ID_W   = 4;
  localparam int unsigned MAX_INFO_W = 32;
  localparam int unsigned MAX_CNT_W  = 64;

  typedef struct packed {
    logic [MAX_ID_W-1:0]   mon_id;
    logic [MAX_INFO_W-1:0] info;
    logic [MAX_CNT_W-1:0]  cycles;
  } rpt_rec_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pkg_fft_output_prio_enc.sv
// Lowest-set-bit priority encoder (combinational).
//   vec     : request vector, bit 0 has highest priority
//   idx_c   : index of the lowest set bit (0 when none set)
//   found_c : OR of vec
module pkg_fft_output_prio_enc #(
  parameter int unsigned N     = 1,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_c   = IDX_W'(i);
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkg_fft_output_deadlock_reporter.sv
// Qualifies a persistent blockage from the HLS deadlock monitors and emits a
// one-shot report record over a valid/ready stream, plus a sticky flag.
//   clock, reset : clock, synchronous active-high reset
//   mon_block    : per-monitor block outputs
//   mon_info     : per-monitor axis_block_info, monitor i at [i*INFO_W +: INFO_W]
//   clear        : pulse; clears deadlock and re-arms from HOLD
//   rpt_valid/rpt_ready, rpt_mon_id, rpt_info, rpt_cycles : report stream
//   deadlock     : sticky deadlock flag
module pkg_fft_output_deadlock_reporter
  import pkg_fft_output_dbg_pkg::*;
#(
  parameter int unsigned NUM_MON = 1,
  parameter int unsigned INFO_W  = 1,
  parameter int unsigned THRESH  = 1024,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned ID_W   = id_width(NUM_MON)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MON-1:0]        mon_block,
  input  logic [NUM_MON*INFO_W-1:0] mon_info,
  input  logic                      clear,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [ID_W-1:0]           rpt_mon_id,
  output logic [INFO_W-1:0]         rpt_info,
  output logic [CNT_W-1:0]          rpt_cycles,
  output logic                      deadlock
);

  dbg_state_e        state;
  logic [CNT_W-1:0]  counter;
  logic [ID_W-1:0]   enc_idx;
  logic              any_blk;
  logic [INFO_W-1:0] sel_info;

  // found_c is the OR of mon_block, so it doubles as any_blk.
  pkg_fft_output_prio_enc #(
    .N     (NUM_MON),
    .IDX_W (ID_W)
  ) u_enc (
    .vec     (mon_block),
    .idx_c   (enc_idx),
    .found_c (any_blk)
  );

  // Info slice of the lowest-index blocked monitor.
  always_comb begin
    sel_info = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      if (enc_idx == ID_W'(i)) sel_info = mon_info[i*INFO_W +: INFO_W];
    end
  end

  // Qualification / report FSM. The declaration writes deadlock after the
  // clear handling, so a same-cycle clear loses to a new declaration.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      rpt_valid  <= 1'b0;
      rpt_mon_id <= '0;
      rpt_info   <= '0;
      rpt_cycles <= '0;
      deadlock   <= 1'b0;
    end else begin
      if (clear) deadlock <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          if (any_blk) begin
            if (THRESH == 1) begin
              counter    <= CNT_W'(THRESH);
              rpt_mon_id <= enc_idx;
              rpt_info   <= sel_info;
              rpt_cycles <= CNT_W'(THRESH);
              deadlock   <= 1'b1;
              rpt_valid  <= 1'b1;
              state      <= REPORT;
            end else begin
              counter <= CNT_W'(1);
              state   <= QUAL;
            end
          end
        end
        QUAL: begin
          if (!any_blk) begin
            counter <= '0;
            state   <= IDLE;
          end else if (counter == CNT_W'(THRESH - 1)) begin
            counter    <= CNT_W'(THRESH);
            rpt_mon_id <= enc_idx;
            rpt_info   <= sel_info;
            rpt_cycles <= CNT_W'(THRESH);
            deadlock   <= 1'b1;
            rpt_valid  <= 1'b1;
            state      <= REPORT;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Re-arm once the blockage clears, or immediately on clear.
          if (clear || !any_blk) begin
            counter <= '0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkg_fft_output_deadlock_reporter.sv
// Directed bench: THRESH=8 instance for the main scenarios, THRESH=1 instance
// for the single-cycle qualification and reset-during-report cases.
module tb_pkg_fft_output_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  mon_block;
  logic [15:0] mon_info;
  logic        clear;
  logic        rpt_ready;

  logic        rpt_valid, deadlock;
  logic [1:0]  rpt_mon_id;
  logic [3:0]  rpt_info;
  logic [31:0] rpt_cycles;

  logic        t1_valid, t1_deadlock;
  logic [1:0]  t1_mon_id;
  logic [3:0]  t1_info;
  logic [31:0] t1_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pkg_fft_output_deadlock_reporter #(
    .NUM_MON(4), .INFO_W(4), .THRESH(8), .CNT_W(32)
  ) u_dut (
    .clock(clock), .reset(reset), .mon_block(mon_block), .mon_info(mon_info),
    .clear(clear), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_mon_id(rpt_mon_id), .rpt_info(rpt_info), .rpt_cycles(rpt_cycles),
    .deadlock(deadlock)
  );

  pkg_fft_output_deadlock_reporter #(
    .NUM_MON(4), .INFO_W(4), .THRESH(1), .CNT_W(32)
  ) u_dut_t1 (
    .clock(clock), .reset(reset), .mon_block(mon_block), .mon_info(mon_info),
    .clear(clear), .rpt_valid(t1_valid), .rpt_ready(rpt_ready),
    .rpt_mon_id(t1_mon_id), .rpt_info(t1_info), .rpt_cycles(t1_cycles),
    .deadlock(t1_deadlock)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_rec(input string tag, input logic [1:0] id, input logic [3:0] info,
                         input logic [31:0] cyc);
    chk({tag, "_valid"}, 64'(rpt_valid), 64'd1);
    chk({tag, "_id"},    64'(rpt_mon_id), 64'(id));
    chk({tag, "_info"},  64'(rpt_info), 64'(info));
    chk({tag, "_cyc"},   64'(rpt_cycles), 64'(cyc));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int early;
    reset = 1'b1; mon_block = '0; mon_info = '0; clear = 1'b0; rpt_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_valid", 64'(rpt_valid), 64'd0);
    chk("rst_dl",    64'(deadlock), 64'd0);
    chk("rst_id",    64'(rpt_mon_id), 64'd0);
    chk("rst_info",  64'(rpt_info), 64'd0);
    chk("rst_cyc",   64'(rpt_cycles), 64'd0);

    // Monitor 2 blocked for 8 samples; report visible after the 8th edge.
    mon_block = 4'b0100; mon_info = 16'h0100;
    early = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (rpt_valid) early++;
    end
    chk("t1_no_early", 64'(early), 64'd0);
    step();
    chk_rec("t1_rec", 2'd2, 4'd1, 32'd8);
    chk("t1_dl", 64'(deadlock), 64'd1);
    // Blockage vanishing during REPORT does not withdraw valid.
    mon_block = 4'b0000;
    step();
    chk("t1_hold_valid", 64'(rpt_valid), 64'd1);
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    chk("t1_hs_drop", 64'(rpt_valid), 64'd0);
    step();
    chk("t1_dl_sticky", 64'(deadlock), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t1_clear_dl", 64'(deadlock), 64'd0);

    // 7 high, 1 low, 7 high: no report; one more high completes 8 in a row.
    mon_block = 4'b1010; mon_info = 16'hA050;
    early = 0;
    for (int i = 0; i < 7; i++) begin step(); if (rpt_valid) early++; end
    mon_block = 4'b0000;
    step();
    if (rpt_valid) early++;
    mon_block = 4'b1010;
    for (int i = 0; i < 7; i++) begin step(); if (rpt_valid) early++; end
    chk("gap_no_rpt", 64'(early), 64'd0);
    chk("gap_dl", 64'(deadlock), 64'd0);
    step();
    chk_rec("gap_rec", 2'd1, 4'd5, 32'd8);

    // Backpressure: record frozen while inputs change underneath it.
    mon_block = 4'b1011; mon_info = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_rec("bp_rec", 2'd1, 4'd5, 32'd8);
    end
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    chk("bp_hs_drop", 64'(rpt_valid), 64'd0);

    // Block persists in HOLD: no second report without clear.
    early = 0;
    for (int i = 0; i < 100; i++) begin step(); if (rpt_valid) early++; end
    chk("hold_no_rpt", 64'(early), 64'd0);
    chk("hold_dl", 64'(deadlock), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("rearm_dl", 64'(deadlock), 64'd0);
    early = 0;
    for (int i = 0; i < 7; i++) begin step(); if (rpt_valid) early++; end
    chk("rearm_no_early", 64'(early), 64'd0);
    step();
    chk_rec("rearm_rec", 2'd0, 4'd4, 32'd8);
    chk("rearm_dl1", 64'(deadlock), 64'd1);

    // clear during REPORT: valid and record untouched, flag cleared.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_rec("clr_rpt", 2'd0, 4'd4, 32'd8);
    chk("clr_rpt_dl", 64'(deadlock), 64'd0);
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    mon_block = 4'b0000;
    step();

    // clear coinciding with the declaration: declaration wins.
    mon_block = 4'b1000; mon_info = 16'hA000;
    for (int i = 0; i < 7; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_rec("clr_decl", 2'd3, 4'hA, 32'd8);
    chk("clr_decl_dl", 64'(deadlock), 64'd1);
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    mon_block = 4'b0000;

    // THRESH=1 instance: one blocked sample reports next cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("th1_rst_valid", 64'(t1_valid), 64'd0);
    mon_block = 4'b0010; mon_info = 16'h0030;
    step();
    chk("th1_valid", 64'(t1_valid), 64'd1);
    chk("th1_id",    64'(t1_mon_id), 64'd1);
    chk("th1_info",  64'(t1_info), 64'd3);
    chk("th1_cyc",   64'(t1_cycles), 64'd1);
    chk("th1_dl",    64'(t1_deadlock), 64'd1);
    chk("th1_main_quiet", 64'(rpt_valid), 64'd0);

    // Reset during REPORT clears everything at the edge.
    reset = 1'b1;
    step();
    chk("rr_valid", 64'(t1_valid), 64'd0);
    chk("rr_id",    64'(t1_mon_id), 64'd0);
    chk("rr_info",  64'(t1_info), 64'd0);
    chk("rr_cyc",   64'(t1_cycles), 64'd0);
    chk("rr_dl",    64'(t1_deadlock), 64'd0);
    reset = 1'b0;
    mon_block = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
